// File: rtl/bram_burst_reader.sv
// Streams a burst of consecutive words out of a synchronous-read block RAM
// onto a valid/ready interface, with a 2-entry skid buffer for backpressure.
module bram_burst_reader #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 11
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  length,
    output logic              busy,
    output logic              done,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    input  logic              m_ready
);

    localparam int unsigned OCC_W = 3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic [ADDR_W-1:0]             base_q;
    logic [LEN_W-1:0]              len_q;
    logic [LEN_W-1:0]              issued;
    logic [LEN_W-1:0]              recv;
    logic                          inflight;

    logic [1:0][DATA_W-1:0]        fifo_data;
    logic [1:0]                    fifo_last;
    logic                          rd_ptr;
    logic                          wr_ptr;
    logic [1:0]                    count;

    logic                          accept;
    logic                          issue;
    logic                          push;
    logic                          pop;
    logic [OCC_W-1:0]              occ;

    assign push = inflight;
    assign pop  = m_valid & m_ready;

    // Slots already committed after this cycle's pop; a read may be issued if one remains.
    assign occ  = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);

    // Next-state and read-issue decode
    always_comb begin
        next_state = state;
        accept     = 1'b0;
        issue      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    next_state = (length == '0) ? S_FIN : S_RUN;
                end
            end
            S_RUN: begin
                issue = (issued < len_q) && (occ < OCC_W'(2));
                if (pop && m_last) begin
                    next_state = S_FIN;
                end
            end
            S_FIN: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // State register with registered status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state == S_RUN);
            done  <= (next_state == S_FIN);
        end
    end

    // Burst bookkeeping: captured request and issue counter
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q   <= '0;
            len_q    <= '0;
            issued   <= '0;
            inflight <= 1'b0;
        end else begin
            if (accept) begin
                base_q <= base_addr;
                len_q  <= length;
                issued <= '0;
            end else if (issue) begin
                issued <= issued + LEN_W'(1);
            end
            inflight <= issue;
        end
    end

    // Two-entry output FIFO; each entry carries its own last-word flag
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_data <= '0;
            fifo_last <= '0;
            rd_ptr    <= 1'b0;
            wr_ptr    <= 1'b0;
            count     <= '0;
            recv      <= '0;
        end else begin
            if (accept) begin
                recv <= '0;
            end else if (push) begin
                fifo_data[wr_ptr] <= ram_dout;
                fifo_last[wr_ptr] <= (recv == len_q - LEN_W'(1));
                wr_ptr            <= ~wr_ptr;
                recv              <= recv + LEN_W'(1);
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(push) - 2'(pop);
        end
    end

    assign ram_en   = issue;
    assign ram_addr = base_q + ADDR_W'(issued);
    assign m_valid  = (count != 2'd0);
    assign m_data   = fifo_data[rd_ptr];
    assign m_last   = m_valid & fifo_last[rd_ptr];

endmodule

// File: doc/bram_burst_reader.md
Name: bram_burst_reader

Overview:
- Reads a burst of LENGTH consecutive words from a single-port block RAM, starting at BASE_ADDR.
- Presents the words on a valid/ready stream output with full backpressure support.
- Read-side counterpart of single_port_ram_ctrl: it drains a RAM region that the controller or another writer has filled.
- Sits between the RAM's port and a downstream consumer, e.g. a UART transmitter or checker.

Parameters:
DATA_W, 16, RAM word width and stream data width
ADDR_W, 10, RAM address width
LEN_W, 11, width of the burst length field; max burst is 2^LEN_W-1 words

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-high reset
start  input  1  one-cycle request; sampled only in IDLE
base_addr  input  ADDR_W  first RAM address; captured when start is accepted
length  input  LEN_W  word count; captured when start is accepted
busy  output  1  high from the cycle after start acceptance until done
done  output  1  one-cycle pulse when the burst completes
ram_en  output  1  RAM read enable
ram_addr  output  ADDR_W  RAM read address
ram_dout  input  DATA_W  RAM read data, valid exactly 1 cycle after ram_en (synchronous read)
m_valid  output  1  stream data valid
m_data  output  DATA_W  stream data
m_last  output  1  high with the final word of the burst
m_ready  input  1  downstream accept

Behaviour:
- Reset: state=IDLE; busy, done, ram_en, m_valid and m_last are 0; ram_addr, m_data and internal counters are 0; the 2-entry output buffer is emptied. Reset mid-burst aborts immediately: no done pulse, and no further ram_en after the reset edge.
- States:
  - IDLE: start=1 at an edge captures base_addr/length and moves to RUN, or to FIN if length==0.
  - RUN: issues reads and streams data out. Moves to FIN at the edge where the handshake with m_last=1 occurs.
  - FIN: done=1 for one cycle, busy=0, then returns to IDLE.
- busy=1 in RUN only.
- start outside IDLE (including FIN) is ignored.
- Read issue: ram_en=1 in a RUN cycle iff issued<length and (buf_count + inflight − pop) < 2.
  - inflight = ram_en of the previous cycle.
  - pop = m_valid&m_ready.
  - The buffer never overflows.
  - ram_addr = base_addr + issued, modulo 2^ADDR_W, so the address wraps from 2^ADDR_W−1 to 0.
- The RAM word is written into the 2-entry FIFO at the edge after the ram_en cycle.
- m_valid = buffer non-empty; m_data = buffer head.
- m_data and m_last hold stable while m_valid=1 and m_ready=0.
- m_last=1 iff the head word is burst word index length−1.
- Latency: start sampled at edge E0 → first ram_en in the cycle after E0 → first m_valid after E2 (3 cycles).
- With m_ready held at 1, one word transfers per cycle with no bubbles. The burst completes at edge E(length+2), and done is high in the following cycle.
- m_ready=0 stalls issue after at most 2 words are held (buffered plus in flight). Reads resume in the same cycle m_ready returns, because pop credits the slot combinationally.
- m_ready may be asserted with m_valid=0; this has no effect.
- No RAM read is issued outside RUN.

Test Plan:
- RAM preloaded mem[i]=i*3; base=0x010, length=4, m_ready=1 → m_data 0x030,0x033,0x036,0x039 on 4 consecutive cycles starting 3 cycles after start; m_last on 0x039; done pulses 1 cycle later; exactly 4 ram_en cycles.
- Same burst, m_ready toggled 1,0,0,1,0,1… → identical data order, no drops or duplicates; data held stable while stalled; never more than 2 reads outstanding plus buffered.
- length=0 → done pulses in the cycle after start; ram_en and m_valid stay 0.
- base=0x3FE, length=4 (ADDR_W=10) → ram_addr sequence 0x3FE,0x3FF,0x000,0x001.
- start re-pulsed mid-burst with different base/length → ignored; original burst completes unchanged.
- rst pulsed after 2 of 8 words transferred → all outputs return to reset values on the next edge with no done pulse; a new start then runs a clean full burst.
